// File: rtl/cp0_pkg.sv
// Shared CP0 definitions for the exception controller: FSM state type,
// Status bit positions, ExcCode constants, exception vector and a Cause
// packing helper.
package cp0_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned INT_W        = 6;
  localparam int unsigned EXC_CODE_W   = 5;

  // Status register bit positions
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 10;
  localparam int unsigned STATUS_IM_HI = 15;

  // ExcCode values
  localparam logic [EXC_CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_CODE_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_CODE_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'd12;

  localparam logic [XLEN-1:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAVE   = 2'd1,
    ST_VECTOR = 2'd2,
    ST_RETURN = 2'd3
  } exc_state_e;

  // Cause layout: BD at 31, pending interrupts at 15:10, ExcCode at 6:2
  function automatic logic [XLEN-1:0] cause_pack(input logic                  bd,
                                                 input logic [INT_W-1:0]      ip,
                                                 input logic [EXC_CODE_W-1:0] code);
    return {bd, 15'b0, ip, 3'b0, code, 2'b0};
  endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-stage register chain for sampling asynchronous interrupt lines.
// Ports: clk, rst_n (async active-low), i_d (raw lines), o_q (sampled lines,
// STAGES cycles behind i_d).
module int_sync #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // Shift chain; stage 0 captures the raw inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt sequencer. Accepts a committed exception, a
// pending enabled interrupt or an ERET while idle, then emits registered
// single-cycle write strobes toward Status/Cause/EPC and a fetch redirect
// with flush.
// Ports: clk, reset (async active-low); status_q/epc_q current CP0 values;
// int_req raw interrupt lines; exc_valid/exc_code/commit_pc/commit_bd/eret
// from commit; *_we/*_wdata register writes; redirect_valid/redirect_pc,
// flush, busy.
// Build option: define EXC_CTRL_INT_SYNC_EN to sample int_req through a
// two-flop synchronizer instead of a single register.
module exc_ctrl
  import cp0_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       status_q,
  input  logic [XLEN-1:0]       epc_q,
  input  logic [INT_W-1:0]      int_req,
  input  logic                  exc_valid,
  input  logic [EXC_CODE_W-1:0] exc_code,
  input  logic [XLEN-1:0]       commit_pc,
  input  logic                  commit_bd,
  input  logic                  eret,
  output logic                  status_we,
  output logic [XLEN-1:0]       status_wdata,
  output logic                  cause_we,
  output logic [XLEN-1:0]       cause_wdata,
  output logic                  epc_we,
  output logic [XLEN-1:0]       epc_wdata,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  flush,
  output logic                  busy
);

`ifdef EXC_CTRL_INT_SYNC_EN
  localparam int unsigned SYNC_STAGES = 2;
`else
  localparam int unsigned SYNC_STAGES = 1;
`endif

  logic [INT_W-1:0] w_int_s;
  logic             w_int_pend;

  int_sync #(
    .WIDTH  (INT_W),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (int_req),
    .o_q   (w_int_s)
  );

  assign w_int_pend = (|(w_int_s & status_q[STATUS_IM_HI:STATUS_IM_LO]))
                    & status_q[STATUS_IE] & ~status_q[STATUS_EXL];

  exc_state_e r_state, w_next_state;

  logic            w_status_we, w_cause_we, w_epc_we, w_redirect_valid, w_flush, w_busy;
  logic [XLEN-1:0] w_status_wdata, w_cause_wdata, w_epc_wdata, w_redirect_pc;

  logic            r_status_we, r_cause_we, r_epc_we, r_redirect_valid, r_flush, r_busy;
  logic [XLEN-1:0] r_status_wdata, r_cause_wdata, r_epc_wdata, r_redirect_pc;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state plus the output values of the state being entered; the
  // output registers load these so every pulse coincides with its state.
  always_comb begin
    w_next_state     = r_state;
    w_status_we      = 1'b0;
    w_status_wdata   = '0;
    w_cause_we       = 1'b0;
    w_cause_wdata    = '0;
    w_epc_we         = 1'b0;
    w_epc_wdata      = '0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_flush          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (exc_valid || w_int_pend) begin
          // Entering SAVE: capture the faulting context this cycle
          w_next_state              = ST_SAVE;
          w_epc_we                  = 1'b1;
          w_epc_wdata               = commit_pc;
          w_cause_we                = 1'b1;
          w_cause_wdata             = exc_valid ? cause_pack(commit_bd, w_int_s, exc_code)
                                                : cause_pack(commit_bd, w_int_s, EXC_INT);
          w_status_we               = 1'b1;
          w_status_wdata            = status_q;
          w_status_wdata[STATUS_EXL] = 1'b1;
        end else if (eret) begin
          // Entering RETURN: drop EXL and jump back to EPC
          w_next_state              = ST_RETURN;
          w_status_we               = 1'b1;
          w_status_wdata            = status_q;
          w_status_wdata[STATUS_EXL] = 1'b0;
          w_redirect_valid          = 1'b1;
          w_redirect_pc             = epc_q;
          w_flush                   = 1'b1;
        end
      end
      ST_SAVE: begin
        w_next_state     = ST_VECTOR;
        w_redirect_valid = 1'b1;
        w_redirect_pc    = EXC_VECTOR;
        w_flush          = 1'b1;
      end
      ST_VECTOR: w_next_state = ST_IDLE;
      ST_RETURN: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase

    w_busy = (w_next_state != ST_IDLE);
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_status_we      <= 1'b0;
      r_status_wdata   <= '0;
      r_cause_we       <= 1'b0;
      r_cause_wdata    <= '0;
      r_epc_we         <= 1'b0;
      r_epc_wdata      <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_status_we      <= w_status_we;
      r_status_wdata   <= w_status_wdata;
      r_cause_we       <= w_cause_we;
      r_cause_wdata    <= w_cause_wdata;
      r_epc_we         <= w_epc_we;
      r_epc_wdata      <= w_epc_wdata;
      r_redirect_valid <= w_redirect_valid;
      r_redirect_pc    <= w_redirect_pc;
      r_flush          <= w_flush;
      r_busy           <= w_busy;
    end
  end

  assign status_we      = r_status_we;
  assign status_wdata   = r_status_wdata;
  assign cause_we       = r_cause_we;
  assign cause_wdata    = r_cause_wdata;
  assign epc_we         = r_epc_we;
  assign epc_wdata      = r_epc_wdata;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_flush;
  assign busy           = r_busy;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus random stimulus
// compared each cycle against a timeline model of expected outputs.
module tb_exc_ctrl;

`ifdef EXC_CTRL_INT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] status_q, epc_q, commit_pc;
  logic [5:0]  int_req;
  logic        exc_valid, commit_bd, eret;
  logic [4:0]  exc_code;
  logic        status_we, cause_we, epc_we, redirect_valid, flush, busy;
  logic [31:0] status_wdata, cause_wdata, epc_wdata, redirect_pc;

  exc_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .status_q       (status_q),
    .epc_q          (epc_q),
    .int_req        (int_req),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .commit_pc      (commit_pc),
    .commit_bd      (commit_bd),
    .eret           (eret),
    .status_we      (status_we),
    .status_wdata   (status_wdata),
    .cause_we       (cause_we),
    .cause_wdata    (cause_wdata),
    .epc_we         (epc_we),
    .epc_wdata      (epc_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit        status_we;
    bit [31:0] status_wdata;
    bit        cause_we;
    bit [31:0] cause_wdata;
    bit        epc_we;
    bit [31:0] epc_wdata;
    bit        redirect_valid;
    bit [31:0] redirect_pc;
    bit        flush;
    bit        busy;
  } exp_t;

  exp_t     exp_tl  [DEPTH];
  bit [5:0] irq_hist[DEPTH];
  int       cyc;
  int       n_checks;
  int       n_fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check("status_we",      32'(status_we),      32'(e.status_we));
    check("status_wdata",   status_wdata,        e.status_wdata);
    check("cause_we",       32'(cause_we),       32'(e.cause_we));
    check("cause_wdata",    cause_wdata,         e.cause_wdata);
    check("epc_we",         32'(epc_we),         32'(e.epc_we));
    check("epc_wdata",      epc_wdata,           e.epc_wdata);
    check("redirect_valid", 32'(redirect_valid), 32'(e.redirect_valid));
    check("redirect_pc",    redirect_pc,         e.redirect_pc);
    check("flush",          32'(flush),          32'(e.flush));
    check("busy",           32'(busy),           32'(e.busy));
  endtask

  // One cycle: check outputs for this cycle, drive inputs, schedule the
  // model's expected outputs for the following cycles. Returns 1 after posedge.
  task automatic step(input logic [31:0] st, input logic [31:0] epc, input logic [5:0] irq,
                      input logic ev, input logic [4:0] code, input logic [31:0] pc,
                      input logic bd, input logic er);
    exp_t     e;
    bit [5:0] ints;
    bit       pend;
    @(negedge clk);
    check_outputs(exp_tl[cyc]);
    status_q = st; epc_q = epc; int_req = irq; exc_valid = ev;
    exc_code = code; commit_pc = pc; commit_bd = bd; eret = er;
    irq_hist[cyc] = irq;
    ints = (cyc >= LAT) ? irq_hist[cyc-LAT] : 6'd0;
    pend = ((ints & st[15:10]) != 6'd0) && st[0] && !st[1];
    if (!exp_tl[cyc].busy) begin
      if (ev || pend) begin
        e = '0;
        e.busy         = 1'b1;
        e.epc_we       = 1'b1;
        e.epc_wdata    = pc;
        e.cause_we     = 1'b1;
        e.cause_wdata  = (bd ? 32'h8000_0000 : 32'd0) + 32'(ints) * 1024
                       + (ev ? 32'(code) : 32'd0) * 4;
        e.status_we    = 1'b1;
        e.status_wdata = st | 32'h2;
        exp_tl[cyc+1]  = e;
        e = '0;
        e.busy           = 1'b1;
        e.redirect_valid = 1'b1;
        e.flush          = 1'b1;
        e.redirect_pc    = 32'hBFC0_0380;
        exp_tl[cyc+2]    = e;
      end else if (er) begin
        e = '0;
        e.busy           = 1'b1;
        e.status_we      = 1'b1;
        e.status_wdata   = st & ~32'h2;
        e.redirect_valid = 1'b1;
        e.flush          = 1'b1;
        e.redirect_pc    = epc;
        exp_tl[cyc+1]    = e;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_step(input logic [31:0] st);
    step(st, 32'd0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Reset asserted mid-cycle; everything in flight is abandoned
  task automatic reset_pulse();
    @(negedge clk);
    check_outputs(exp_tl[cyc]);
    status_q = '0; epc_q = '0; int_req = '0; exc_valid = 1'b0;
    exc_code = '0; commit_pc = '0; commit_bd = 1'b0; eret = 1'b0;
    irq_hist[cyc] = 6'd0;
    #2 reset = 1'b0;
    #1 check_outputs('0);
    for (int k = 0; k < 8; k++) exp_tl[cyc+k] = '0;
    @(posedge clk); #1; cyc++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_outputs('0);
      irq_hist[cyc] = 6'd0;
      @(posedge clk); #1; cyc++;
    end
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] st;
    logic [5:0]  irq;
    n_checks = 0; n_fails = 0; cyc = 0;
    reset = 1'b0;
    status_q = '0; epc_q = '0; int_req = '0; exc_valid = 1'b0;
    exc_code = '0; commit_pc = '0; commit_bd = 1'b0; eret = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs('0);
    reset = 1'b1;

    repeat (4) idle_step(32'h0000_0401);

    // Interrupt line 0 held with IE and IM0 enabled
    step(32'h0000_0401, 32'd0, 6'b000001, 1'b0, 5'd0, 32'h8000_0400, 1'b0, 1'b0);
    repeat (LAT) step(32'h0000_0401, 32'd0, 6'b000001, 1'b0, 5'd0, 32'h8000_0400, 1'b0, 1'b0);
    check("irq_save_we",    32'(status_we),      32'd1);
    check("irq_cause_ip",   32'(cause_wdata[15:10]), 32'd1);
    check("irq_cause_code", 32'(cause_wdata[6:2]),   32'd0);
    check("irq_status",     status_wdata,        32'h0000_0403);
    step(32'h0000_0403, 32'd0, 6'b000001, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("irq_vector",     redirect_pc,         32'hBFC0_0380);
    repeat (4) idle_step(32'h0000_0403);

    // Synchronous exception in a delay slot
    step(32'd0, 32'd0, 6'd0, 1'b1, 5'd8, 32'h8000_1000, 1'b1, 1'b0);
    check("exc_epc",        epc_wdata,           32'h8000_1000);
    check("exc_cause",      cause_wdata,         32'h8000_0020);
    idle_step(32'd0);
    check("exc_redirect",   32'(redirect_valid), 32'd1);
    check("exc_flush",      32'(flush),          32'd1);
    check("exc_vector",     redirect_pc,         32'hBFC0_0380);
    repeat (2) idle_step(32'd0);

    // Exception and pending interrupt together: exception wins, EXL then masks
    repeat (LAT + 1) step(32'h0000_0403, 32'd0, 6'b000001, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(32'h0000_0401, 32'd0, 6'b000001, 1'b1, 5'd8, 32'h8000_3000, 1'b0, 1'b0);
    check("both_code",      32'(cause_wdata[6:2]), 32'd8);
    check("both_epc",       epc_wdata,           32'h8000_3000);
    repeat (4) step(32'h0000_0403, 32'd0, 6'b000001, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("both_masked",    32'(busy),           32'd0);
    repeat (LAT + 2) idle_step(32'd0);

    // ERET
    step(32'h0000_0403, 32'h8000_2004, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    check("eret_status",    status_wdata,        32'h0000_0401);
    check("eret_pc",        redirect_pc,         32'h8000_2004);
    check("eret_busy",      32'(busy),           32'd1);
    idle_step(32'd0);
    check("eret_busy_end",  32'(busy),           32'd0);

    // Reset during SAVE
    step(32'd0, 32'd0, 6'd0, 1'b1, 5'd12, 32'h8000_5000, 1'b0, 1'b0);
    check("pre_rst_save",   32'(epc_we),         32'd1);
    reset_pulse();
    idle_step(32'd0);
    check("post_rst_novec", 32'(redirect_valid), 32'd0);
    check("post_rst_idle",  32'(busy),           32'd0);
    repeat (2) idle_step(32'd0);

    // Random traffic, including inputs applied while busy
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) reset_pulse();
      st     = $urandom;
      st[0]  = ($urandom_range(0, 3) != 0);
      st[1]  = ($urandom_range(0, 3) == 0);
      irq    = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
      step(st, $urandom, irq, ($urandom_range(0, 9) == 0), 5'($urandom),
           $urandom, 1'($urandom), ($urandom_range(0, 7) == 0));
    end
    repeat (4) idle_step(32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
